pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multi-cycle next-PC controller for the monocycle core's fetch/branch path. Fetches through a request/acknowledge handshake with instruction memory. Holds the PC during fetch latency and execute stalls. In the execute cycle it consumes the branch unit's NextPcSrc decision and selects either the sequential PC or the branch target, with a one-cycle pipeline flush on redirect. Sits between the control unit/branch unit and the instruction-memory interface.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
fetch_req  output  1  instruction fetch request
fetch_addr  output  32  fetch address, always equal to pc
fetch_ack  input  1  imem has returned the instruction for fetch_addr
stall  input  1  hold the EXEC state (hazard/multicycle op)
BrOp  input  5  branch opcode from control unit; branch instr when BrOp[4]|BrOp[3]
NextPcSrc  input  1  branch-taken decision from branch unit
target  input  32  branch/jump target address
pc  output  32  current program counter
flush  output  1  one-cycle squash of in-flight decode
misalign  output  1  sticky misaligned-target trap flag
taken_count  output  32  taken-branch counter (present only with BRANCH_STATS_EN)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- States: FETCH, EXEC, REDIRECT, TRAP.
- Reset (rst=1 at an edge): state=FETCH, pc=RESET_PC, flush=0, misalign=0, taken_count=0. Reset takes effect from any state, including mid-fetch, EXEC stall, REDIRECT and TRAP.
- fetch_req = (state==FETCH), decoded from registered state. fetch_addr = pc at all times.
- FETCH:
  - fetch_ack=1 -> EXEC next cycle.
  - Otherwise stay in FETCH with pc unchanged. Unbounded wait.
  - fetch_ack outside FETCH is ignored.
- EXEC:
  - taken = NextPcSrc & (BrOp[4] | BrOp[3]). BrOp=00xxx is never taken, regardless of NextPcSrc.
  - stall=1: stay in EXEC, pc held. stall has priority over any taken decision in the same cycle.
  - stall=0, taken=0: pc <= pc + PC_STEP (mod 2^32, so 32'hFFFF_FFFC wraps to 0), then FETCH.
  - stall=0, taken=1, target[1:0]==0: pc <= target, then REDIRECT.
  - stall=0, taken=1, target[1:0]!=0: pc held, misalign <= 1, then TRAP.
- REDIRECT:
  - flush=1 for exactly this one cycle, fetch_req=0.
  - Unconditionally -> FETCH next cycle.
- TRAP:
  - fetch_req=0, flush=0, pc frozen, misalign=1.
  - Exit only via rst.
- flush is registered: it is 1 only while state==REDIRECT.
- Minimum instruction latency: 2 cycles (FETCH with immediate ack, then EXEC); a taken branch adds 1 cycle (REDIRECT).
- Inputs sampled only in the states listed above. X on BrOp, NextPcSrc or target outside EXEC must not affect state.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - taken_count port exists.
  - 32-bit counter increments by 1 on each EXEC->REDIRECT transition.
  - Saturates at 32'hFFFF_FFFF.
  - Not incremented on the EXEC->TRAP transition.
  - Cleared by rst.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset then sequential: rst 1 cycle; fetch_ack=1 every FETCH; BrOp=5'b00000. Expect pc 0x0 -> 0x4 -> 0x8, each step taking 2 cycles; flush stays 0.
2. Taken branch: in EXEC at pc=0x8, BrOp=5'b01000, NextPcSrc=1, target=0x100. Expect next state REDIRECT with flush=1 for one cycle and fetch_req=0, then fetch_addr=0x100. With BRANCH_STATS_EN, taken_count=1.
3. Never-branch gating: BrOp=5'b00000, NextPcSrc=1, target=0x200 at pc=0x10. Expect pc=0x14 and no flush.
4. Stall priority and fetch wait:
   - Hold fetch_ack=0 for 3 cycles. Expect fetch_req=1 and pc stable throughout.
   - Then in EXEC, stall=1 for 2 cycles with a taken branch to 0x40. Expect pc held; redirect to 0x40 only after stall drops.
5. Misaligned target: taken branch (BrOp=5'b10000) with target=0x102. Expect misalign=1 and TRAP with fetch_req=0 and pc frozen for 5+ cycles. Then rst: pc=RESET_PC, misalign=0.
6. Wrap and mid-op reset:
   - pc=0xFFFF_FFFC, not taken. Expect pc=0x0000_0000.
   - rst asserted during REDIRECT. Expect flush=0 and state FETCH with pc=RESET_PC on the next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: fetch handshake, execute-stage branch resolution, one-cycle flush on redirect.
// Latency: 2 cycles per instruction minimum (FETCH + EXEC); a taken branch adds 1 REDIRECT cycle.
// Backpressure: holds in FETCH until fetch_ack and in EXEC while stall; a misaligned taken target parks in TRAP until rst.
// Optional: define BRANCH_STATS_EN to add the saturating taken_count port/counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic        stall,
  input  logic [4:0]  BrOp,
  input  logic        NextPcSrc,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic        flush,
  output logic        misalign
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] taken_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_EXEC     = 2'd1,
    S_REDIRECT = 2'd2,
    S_TRAP     = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_d;
  logic        misalign_d;
  logic        taken;

  // Branch inputs are only looked at in EXEC so junk/X elsewhere cannot leak into state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    misalign_d = misalign;
    taken      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_ack) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // stall wins over any branch decision presented in the same cycle
        if (!stall) begin
          taken = NextPcSrc & (BrOp[4] | BrOp[3]);
          if (!taken) begin
            pc_d    = pc + PC_STEP;
            state_d = S_FETCH;
          end else if (target[1:0] == 2'b00) begin
            pc_d    = target;
            state_d = S_REDIRECT;
          end else begin
            misalign_d = 1'b1;
            state_d    = S_TRAP;
          end
        end
      end
      S_REDIRECT: begin
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State, PC, sticky trap flag and the flush flop; rst wins from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc       <= RESET_PC;
      misalign <= 1'b0;
      flush    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      misalign <= misalign_d;
      // flush is a flop that mirrors "next state is REDIRECT", so it is high exactly in REDIRECT
      flush    <= (state_d == S_REDIRECT);
    end
  end

  // Fetch interface decoded from the registered state.
  always_comb begin
    fetch_req  = (state_q == S_FETCH);
    fetch_addr = pc;
  end

`ifdef BRANCH_STATS_EN
  // Count EXEC->REDIRECT transitions, saturating; misaligned (trapping) branches are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count <= '0;
    end else if ((state_q == S_EXEC) && (state_d == S_REDIRECT) &&
                 (taken_count != 32'hFFFF_FFFF)) begin
      taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic        stall;
  logic [4:0]  BrOp;
  logic        NextPcSrc;
  logic [31:0] target;
  logic [31:0] pc;
  logic        flush;
  logic        misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] exp_taken;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  pc_sequencer #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .stall      (stall),
    .BrOp       (BrOp),
    .NextPcSrc  (NextPcSrc),
    .target     (target),
    .pc         (pc),
    .flush      (flush),
    .misalign   (misalign)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Garbage on the branch inputs outside EXEC must be ignored by the DUT.
  task automatic junk_inputs();
    BrOp      = 5'($urandom);
    NextPcSrc = 1'b1;
    target    = $urandom;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fetch_ack = 1'b0;
    stall     = 1'b0;
    junk_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_pc = 32'h0;
    exp_q.delete();
    exp_q.push_back(32'h0);
`ifdef BRANCH_STATS_EN
    exp_taken = 32'h0;
    check("rst_taken_count", taken_count, exp_taken);
`endif
    check("rst_pc", pc, 32'h0);
    check("rst_fetch_req", {31'b0, fetch_req}, 32'd1);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
  endtask

  // Complete one fetch; the scoreboard supplies the address the DUT must request.
  task automatic do_fetch(input int wait_n);
    logic [31:0] exp;
    int guard;
    guard = 0;
    while (!fetch_req && guard < 8) begin
      junk_inputs();
      @(negedge clk);
      guard++;
    end
    check("fetch_req_seen", {31'b0, fetch_req}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~fetch_addr;
    for (int i = 0; i < wait_n; i++) begin
      fetch_ack = 1'b0;
      junk_inputs();
      @(negedge clk);
      check("wait_fetch_req", {31'b0, fetch_req}, 32'd1);
      check("wait_pc", pc, exp);
    end
    check("fetch_addr", fetch_addr, exp);
    fetch_ack = 1'b1;
    junk_inputs();
    @(negedge clk);
    fetch_ack = 1'b0;
    check("exec_fetch_req", {31'b0, fetch_req}, 32'd0);
    check("exec_pc", pc, exp);
  endtask

  // Drive one EXEC cycle (after optional stalls) and check the resulting transition.
  task automatic do_exec(input logic [4:0] brop, input logic nps, input logic [31:0] tgt,
                         input int stall_n, input bit rst_in_redirect);
    logic tk;
    tk        = nps & (brop[4] | brop[3]);
    BrOp      = brop;
    NextPcSrc = nps;
    target    = tgt;
    for (int i = 0; i < stall_n; i++) begin
      stall     = 1'b1;
      fetch_ack = 1'b1;
      @(negedge clk);
      check("stall_pc", pc, model_pc);
      check("stall_fetch_req", {31'b0, fetch_req}, 32'd0);
      check("stall_flush", {31'b0, flush}, 32'd0);
    end
    stall     = 1'b0;
    fetch_ack = 1'b0;
    @(negedge clk);
    junk_inputs();
    if (!tk) begin
      model_pc = model_pc + 32'd4;
      exp_q.push_back(model_pc);
      check("seq_pc", pc, model_pc);
      check("seq_flush", {31'b0, flush}, 32'd0);
      check("seq_fetch_req", {31'b0, fetch_req}, 32'd1);
    end else if (tgt[1:0] == 2'b00) begin
      model_pc = tgt;
      exp_q.push_back(tgt);
      check("redir_flush", {31'b0, flush}, 32'd1);
      check("redir_fetch_req", {31'b0, fetch_req}, 32'd0);
      check("redir_pc", pc, tgt);
`ifdef BRANCH_STATS_EN
      if (exp_taken != 32'hFFFF_FFFF) exp_taken = exp_taken + 32'd1;
      check("taken_count", taken_count, exp_taken);
`endif
      if (rst_in_redirect) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_pc = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
`ifdef BRANCH_STATS_EN
        exp_taken = 32'h0;
        check("rst_redir_taken_count", taken_count, exp_taken);
`endif
        check("rst_redir_flush", {31'b0, flush}, 32'd0);
        check("rst_redir_pc", pc, 32'h0);
        check("rst_redir_fetch_req", {31'b0, fetch_req}, 32'd1);
      end else begin
        @(negedge clk);
        check("post_redir_flush", {31'b0, flush}, 32'd0);
        check("post_redir_fetch_req", {31'b0, fetch_req}, 32'd1);
        check("post_redir_addr", fetch_addr, tgt);
      end
    end else begin
      check("trap_misalign", {31'b0, misalign}, 32'd1);
      check("trap_fetch_req", {31'b0, fetch_req}, 32'd0);
      check("trap_pc", pc, model_pc);
      for (int i = 0; i < 6; i++) begin
        fetch_ack = 1'b1;
        stall     = 1'($urandom);
        junk_inputs();
        @(negedge clk);
        check("trap_hold_misalign", {31'b0, misalign}, 32'd1);
        check("trap_hold_fetch_req", {31'b0, fetch_req}, 32'd0);
        check("trap_hold_flush", {31'b0, flush}, 32'd0);
        check("trap_hold_pc", pc, model_pc);
      end
`ifdef BRANCH_STATS_EN
      check("trap_taken_count", taken_count, exp_taken);
`endif
      fetch_ack = 1'b0;
      stall     = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    fetch_ack = 1'b0;
    stall     = 1'b0;
    BrOp      = 5'b0;
    NextPcSrc = 1'b0;
    target    = 32'h0;

    do_reset();
    // sequential 0x0 -> 0x4 -> 0x8
    do_fetch(0); do_exec(5'b00000, 1'b0, 32'h0, 0, 1'b0);
    do_fetch(0); do_exec(5'b00000, 1'b0, 32'h0, 0, 1'b0);
    // taken branch at 0x8 to 0x100, then back to 0x10
    do_fetch(0); do_exec(5'b01000, 1'b1, 32'h100, 0, 1'b0);
    do_fetch(0); do_exec(5'b11010, 1'b1, 32'h10, 0, 1'b0);
    // BrOp=00xxx never branches even with NextPcSrc=1
    do_fetch(0); do_exec(5'b00000, 1'b1, 32'h200, 0, 1'b0);
    // slow fetch, then stalled taken branch to 0x40
    do_fetch(3); do_exec(5'b01000, 1'b1, 32'h40, 2, 1'b0);
    // misaligned target traps until reset
    do_fetch(0); do_exec(5'b10000, 1'b1, 32'h102, 0, 1'b0);
    do_reset();
    // wrap-around at the top of the address space
    do_fetch(0); do_exec(5'b10000, 1'b1, 32'hFFFF_FFFC, 0, 1'b0);
    do_fetch(1); do_exec(5'b00111, 1'b1, 32'h8, 1, 1'b0);
    // reset arriving during REDIRECT
    do_fetch(0); do_exec(5'b01000, 1'b1, 32'h80, 0, 1'b1);
    // branch opcode without a taken decision
    do_fetch(0); do_exec(5'b01000, 1'b0, 32'h80, 0, 1'b0);
    do_fetch(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
